// File: rtl/video_pattern_gen.sv
// Raster timing and test-pattern source for the edge-detection video input.
// Pixel rate is half the core clock; every video output is registered and updates on pixel ticks.
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        I_CORE_CLK,
    input  logic        I_RST,
    input  logic        I_EN,
    input  logic [1:0]  I_PATTERN,
    input  logic [23:0] I_COLOR,
    output logic [23:0] O_PIX_DATA,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE,
    output logic        O_PCLK,
    output logic        O_BUSY,
    output logic        O_FRAME_DONE
);
    // state  | meaning
    // S_IDLE | outputs idle, waiting for I_EN at a pixel tick
    // S_RUN  | raster running; leaves only at the frame-wrap tick
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [0:0]     state, state_nxt;
    logic           ph;
    logic [15:0]    h, v, h_nxt, v_nxt;
    logic [7:0]     frame_cnt, fc_nxt;
    logic [BPW-1:0] bar_pos, bar_pos_nxt;
    logic [2:0]     bar_idx, bar_idx_nxt;
    logic [1:0]     pat_q, pat_use;
    logic [23:0]    col_q, col_use;
    logic           start;
    logic           tick;
    logic           h_wrap, v_wrap, frame_wrap;
    logic           run_nxt, de_nxt, hs_act, vs_act;
    logic [23:0]    bar_rgb, pix_nxt;

    // ph is high on the edge where O_PCLK falls, which is the pixel tick
    assign tick       = ph;
    assign O_PCLK     = ph;
    assign h_wrap     = (h == H_LAST);
    assign v_wrap     = (v == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        v_nxt     = v;
        fc_nxt    = frame_cnt;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_EN) begin
                    state_nxt = S_RUN;
                    h_nxt     = 16'd0;
                    v_nxt     = 16'd0;
                    start     = 1'b1;
                end
            end
            S_RUN: begin
                if (h_wrap) begin
                    h_nxt = 16'd0;
                    v_nxt = v_wrap ? 16'd0 : v + 16'd1;
                end else begin
                    h_nxt = h + 16'd1;
                end
                if (frame_wrap) begin
                    fc_nxt = frame_cnt + 8'd1;
                    if (I_EN) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // bar index tracks h with a small counter instead of dividing by BAR_W
    always_comb begin
        bar_pos_nxt = bar_pos + BPW'(1);
        bar_idx_nxt = bar_idx;
        if (h_nxt == 16'd0) begin
            bar_pos_nxt = '0;
            bar_idx_nxt = 3'd0;
        end else if (bar_pos == BAR_LAST) begin
            bar_pos_nxt = '0;
            bar_idx_nxt = bar_idx + 3'd1;
        end
    end

    always_comb begin
        case (bar_idx_nxt)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pat_use = start ? I_PATTERN : pat_q;
        col_use = start ? I_COLOR : col_q;
        run_nxt = (state_nxt == S_RUN);
        de_nxt  = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_act  = run_nxt && (h_nxt >= HS_BEG) && (h_nxt < HS_END);
        vs_act  = run_nxt && (v_nxt >= VS_BEG) && (v_nxt < VS_END);
        case (pat_use)
            2'd0:    pix_nxt = col_use;
            2'd1:    pix_nxt = bar_rgb;
            2'd2:    pix_nxt = {h_nxt[7:0], h_nxt[7:0], h_nxt[7:0]};
            default: pix_nxt = (h_nxt[3] ^ v_nxt[3] ^ fc_nxt[0]) ? 24'hFFFFFF : 24'h000000;
        endcase
        if (!de_nxt) begin
            pix_nxt = 24'h000000;
        end
    end

    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            state        <= S_IDLE;
            ph           <= 1'b0;
            h            <= 16'd0;
            v            <= 16'd0;
            frame_cnt    <= 8'd0;
            bar_pos      <= '0;
            bar_idx      <= 3'd0;
            pat_q        <= 2'd0;
            col_q        <= 24'h000000;
            O_PIX_DATA   <= 24'h000000;
            O_DE         <= 1'b0;
            O_HSYNC      <= ~SYNC_ON;
            O_VSYNC      <= ~SYNC_ON;
            O_BUSY       <= 1'b0;
            O_FRAME_DONE <= 1'b0;
        end else begin
            ph           <= ~ph;
            O_FRAME_DONE <= tick && (state == S_RUN) && frame_wrap;
            if (tick) begin
                state      <= state_nxt;
                h          <= h_nxt;
                v          <= v_nxt;
                frame_cnt  <= fc_nxt;
                bar_pos    <= bar_pos_nxt;
                bar_idx    <= bar_idx_nxt;
                pat_q      <= pat_use;
                col_q      <= col_use;
                O_PIX_DATA <= pix_nxt;
                O_DE       <= de_nxt;
                O_HSYNC    <= hs_act ? SYNC_ON : ~SYNC_ON;
                O_VSYNC    <= vs_act ? SYNC_ON : ~SYNC_ON;
                O_BUSY     <= run_nxt;
            end
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with a 14x7 raster (8/2/2/2, 4/1/1/1, active-low syncs).
module tb_video_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [23:0] color = 24'h123456;
    logic [23:0] pix;
    logic        vsync, hsync, de, pclk, busy, done;

    int checks = 0;
    int failures = 0;
    int edge_n;
    int cyc = 0;
    int last_done = -1;
    bit prev_done = 1'b0;

    video_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0)
    ) dut (
        .I_CORE_CLK  (clk),
        .I_RST       (rst),
        .I_EN        (en),
        .I_PATTERN   (pattern),
        .I_COLOR     (color),
        .O_PIX_DATA  (pix),
        .O_VSYNC     (vsync),
        .O_HSYNC     (hsync),
        .O_DE        (de),
        .O_PCLK      (pclk),
        .O_BUSY      (busy),
        .O_FRAME_DONE(done)
    );

    always #5 clk = ~clk;

    // core edges since reset release; even counts are pixel ticks
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (prev_done) check("done_width", {31'd0, done}, 32'd0);
        if (done) begin
            if (last_done >= 0) check("done_period", cyc - last_done, 196);
            last_done = cyc;
        end
        prev_done = done;
    end

    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (edge_n[0] != 1'b0);
    endtask

    function automatic logic [28:0] exp_vec(input int h, input int v, input logic [1:0] pat,
                                            input logic [23:0] col, input int fc, input bit dn);
        logic        e_de, e_hs, e_vs;
        logic [23:0] d;
        logic [7:0]  hb;
        hb   = h[7:0];
        e_de = (h < 8) && (v < 4);
        e_hs = !(h >= 10 && h < 12);
        e_vs = !(v == 5);
        case (pat)
            2'd0: d = col;
            2'd1: begin
                case (h)
                    0: d = 24'hFFFFFF;
                    1: d = 24'hFFFF00;
                    2: d = 24'h00FFFF;
                    3: d = 24'h00FF00;
                    4: d = 24'hFF00FF;
                    5: d = 24'hFF0000;
                    6: d = 24'h0000FF;
                    default: d = 24'h000000;
                endcase
            end
            2'd2: d = {hb, hb, hb};
            default: d = ((((h / 8) + (v / 8) + fc) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
        if (!e_de) d = 24'h000000;
        return {1'b1, dn, e_de, e_hs, e_vs, d};
    endfunction

    task automatic check_frame(input string tag, input logic [1:0] pat, input logic [23:0] col,
                               input int fc, input bit done0, input int nticks,
                               input int chg_k, input logic [1:0] chg_pat, input int stop_k);
        int h, v;
        int de_n;
        de_n = 0;
        for (int k = 0; k < nticks; k++) begin
            next_tick();
            h = k % 14;
            v = k / 14;
            check(tag, {3'd0, busy, done, de, hsync, vsync, pix},
                  {3'd0, exp_vec(h, v, pat, col, fc, done0 && (k == 0))});
            if (de) de_n++;
            if (k == chg_k) pattern = chg_pat;
            if (k == stop_k) en = 1'b0;
        end
        if (nticks == 98) check({tag, "_de_count"}, de_n, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [28:0] idle_vec;
        logic [28:0] stop_vec;
        idle_vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
        stop_vec = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
        en = 1'b1;
        #12;
        check("reset_outs", {3'd0, busy, done, de, hsync, vsync, pix}, {3'd0, idle_vec});
        check("reset_pclk", {31'd0, pclk}, 32'd0);
        #10 rst = 1'b0;

        // solid colour; switch to bars at v = 1, must not affect this frame
        check_frame("solid", 2'd0, 24'h123456, 0, 1'b0, 98, 14, 2'd1, -1);
        check_frame("bars", 2'd1, 24'h123456, 1, 1'b1, 98, 20, 2'd2, -1);
        check_frame("gray", 2'd2, 24'h123456, 2, 1'b1, 98, 3, 2'd3, -1);
        check_frame("checker_odd", 2'd3, 24'h123456, 3, 1'b1, 98, -1, 2'd0, -1);
        // stop request at v = 2; the frame still runs to completion
        check_frame("checker_even", 2'd3, 24'h123456, 4, 1'b1, 98, -1, 2'd0, 28);

        next_tick();
        check("stop_tick", {3'd0, busy, done, de, hsync, vsync, pix}, {3'd0, stop_vec});
        for (int i = 0; i < 3; i++) begin
            next_tick();
            check("idle", {3'd0, busy, done, de, hsync, vsync, pix}, {3'd0, idle_vec});
        end

        pattern = 2'd0;
        color   = 24'hABCDEF;
        en      = 1'b1;
        check_frame("restart", 2'd0, 24'hABCDEF, 5, 1'b0, 50, -1, 2'd0, -1);

        // asynchronous reset mid-frame, between clock edges
        #3 rst = 1'b1;
        #1;
        check("async_reset", {3'd0, busy, done, de, hsync, vsync, pix}, {3'd0, idle_vec});
        check("async_reset_pclk", {31'd0, pclk}, 32'd0);
        en = 1'b0;
        #2 rst = 1'b0;

        @(posedge clk); #1;
        check("pclk_edge1", {31'd0, pclk}, 32'd1);
        @(posedge clk); #1;
        check("pclk_edge2", {31'd0, pclk}, 32'd0);
        // I_EN pulse covering only the non-tick edge is ignored
        en = 1'b1;
        @(posedge clk); #1;
        check("pclk_edge3", {31'd0, pclk}, 32'd1);
        en = 1'b0;
        next_tick();
        check("en_glitch", {3'd0, busy, done, de, hsync, vsync, pix}, {3'd0, idle_vec});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Pixel-stream source that drives the edge-detection video input interface: 24-bit pixel data plus VSYNC, HSYNC, DE and a forwarded pixel clock. It generates parameterised raster timing and one of four test patterns from the core clock. It serves as the on-chip/FPGA stimulus source and loopback partner for `edge_detection_top`.

## Interface

**Parameters**
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 8.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: HSYNC width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: VSYNC width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted level of HSYNC/VSYNC (0 = active-low).

**Ports**
- `I_CORE_CLK` in 1: single clock. All logic is on the rising edge.
- `I_RST` in 1: asynchronous, active-high reset.
- `I_EN` in 1: run request.
- `I_PATTERN` in 2: pattern select. 0 = solid, 1 = colour bars, 2 = gray ramp, 3 = checkerboard.
- `I_COLOR` in 24: solid colour {R,G,B}.
- `O_PIX_DATA` out 24: pixel {R[23:16],G[15:8],B[7:0]}.
- `O_VSYNC` out 1: vertical sync.
- `O_HSYNC` out 1: horizontal sync.
- `O_DE` out 1: data enable.
- `O_PCLK` out 1: pixel clock, equal to `I_CORE_CLK`/2.
- `O_BUSY` out 1: high while a frame is in progress.
- `O_FRAME_DONE` out 1: one-core-cycle pulse at the end of each frame.

## Operation

**Pixel clock**
- Phase bit `ph` toggles every core cycle; `O_PCLK` = registered `ph`.
- A "pixel tick" is a core edge at which `O_PCLK` goes 1→0.
- All video outputs update only on pixel ticks. The receiver samples on the `O_PCLK` rising edge, mid-pixel.

**Counters**
- `h` counts 0..H_TOTAL-1, with H_TOTAL = sum of the four H parameters.
- `v` counts 0..V_TOTAL-1, with V_TOTAL defined likewise.
- `h` advances every tick while RUN. `v` advances when `h` wraps.
- `frame_cnt` (8-bit, wrapping) increments at each frame wrap.

**Region decode (from the counters)**
- `O_DE` = (h < H_ACTIVE) && (v < V_ACTIVE).
- HSYNC asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- VSYNC asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for whole lines. It therefore changes only at ticks where h = 0.
- Sync outputs drive `SYNC_POL` when asserted and `~SYNC_POL` otherwise.

**Patterns**
- Pattern select is latched at the frame start tick (h = 0, v = 0) and held for the whole frame. `I_COLOR` is latched at the same point.
- 0: the latched `I_COLOR`.
- 1: 8 equal vertical bars, each H_ACTIVE/8 wide, in the order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. The bar index comes from a bar counter, not a divider.
- 2: {h[7:0], h[7:0], h[7:0]}.
- 3: FFFFFF if (h[3] ^ v[3] ^ frame_cnt[0]), else 000000.
- `O_PIX_DATA` = 0 whenever `O_DE` = 0.

**State machine**
- IDLE → RUN: at a tick with `I_EN` = 1. Counters start at h = 0, v = 0, and that pixel is presented at this same tick. `O_BUSY` rises at this tick.
- RUN, at the frame-wrap tick (h = H_TOTAL-1 → 0 and v = V_TOTAL-1 → 0):
  - Pulse `O_FRAME_DONE`.
  - If `I_EN` = 1: stay in RUN; the new frame's pixel (0,0) is presented at this tick.
  - If `I_EN` = 0: go to IDLE; outputs take their idle values at this tick.
- Dropping `I_EN` mid-frame never truncates the frame.
- IDLE outputs: `O_DE` 0, `O_PIX_DATA` 0, syncs inactive, `O_BUSY` 0. `O_PCLK` keeps toggling.

## Timing

- **Reset values:** `O_PIX_DATA` 0, `O_DE` 0, `O_HSYNC` = `O_VSYNC` = ~SYNC_POL, `O_PCLK` 0, `O_BUSY` 0, `O_FRAME_DONE` 0. State is IDLE, counters 0, `ph` 0.
- **First pixel tick after reset:** the second rising edge after `I_RST` deasserts.
- **Start latency:** 0 ticks. The pixel for h = 0, v = 0 is presented at the tick where `I_EN` is first sampled high.
- **Sampling of `I_EN`:** only at ticks. Pulses between ticks are ignored.
- **Output registration:** all outputs are registered, with no combinational path from inputs.
- **Output skew:** data, DE and syncs change together on the same core edge.
- **Frame length:** exactly 2·H_TOTAL·V_TOTAL core cycles.
- **`O_FRAME_DONE` placement:** a one-core-cycle pulse that coincides with the frame-wrap tick.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronous).
- **Pattern change mid-frame:** has no effect until the next frame start.

## Test plan

Small parameters for all scenarios: H = 8/2/2/2 (H_TOTAL = 14), V = 4/1/1/1 (V_TOTAL = 7), SYNC_POL = 0.

1. **Reset:** assert `I_RST` mid-run.
   - All outputs go to reset values asynchronously: syncs = 1, DE = 0, data = 0.
   - `O_PCLK` resumes toggling after release.
2. **Pattern 0, `I_COLOR` = 123456, `I_EN` held high:**
   - DE high for 8 ticks on each of lines 0-3 (32 pixels per frame), all with data 123456.
   - HSYNC low at h = 10-11 on every line; VSYNC low for the whole of line 5.
   - `O_FRAME_DONE` pulses every 196 core cycles.
3. **Pattern 1:** line 0 data is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (one bar per pixel). Data is 0 at h = 8-13.
4. **Pattern 2 then pattern 3:**
   - Pattern 2: data at h = 5 is 050505.
   - Pattern 3, frame 0: (h = 8 is out of range, so use h = 0..7, v = 0..3) every active pixel is 000000.
   - Pattern 3, frame 1: every active pixel is FFFFFF.
5. **Stop request:** drop `I_EN` at v = 2.
   - The frame completes through v = 6.
   - `O_FRAME_DONE` pulses; `O_BUSY` falls at the same tick; no further DE.
   - Re-raising `I_EN` gives DE high with h = 0 data at the sampling tick.
6. **Mid-frame pattern change:** switch `I_PATTERN` from 0 to 1 at v = 1.
   - The remainder of the frame stays solid colour.
   - The next frame shows bars.
